// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-init sequencer.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    START,
    GUARD,
    WAIT,
    GAP,
    DELAY,
    ADV
  } state_t;

  // Register index of all ones is the escape code; with value FF it ends the table.
  localparam logic [7:0] END_REGV  = 8'hFF;
  localparam int         GUARD_LEN = 2;

endpackage

// File: rtl/i2c_init_seq_if.sv
// ROM fetch and byte-writer handshake bundle between the sequencer and its neighbours.
interface i2c_init_seq_if #(
  parameter int REGI_MSB = 7,
  parameter int ADDR_MSB = 7
);
  logic [ADDR_MSB:0]   tbl_addr;
  logic [REGI_MSB+8:0] tbl_data;
  logic [REGI_MSB:0]   i2c_regi;
  logic [7:0]          i2c_regv;
  logic                i2c_start;
  logic                i2c_done;

  modport master (
    output tbl_addr, i2c_regi, i2c_regv, i2c_start,
    input  tbl_data, i2c_done
  );

  modport slave (
    input  tbl_addr, i2c_regi, i2c_regv, i2c_start,
    output tbl_data, i2c_done
  );
endinterface

// File: rtl/i2c_delay_ms.sv
// Down-counter shared by the post-write gap (plain cycle count) and the
// millisecond delay entries (cycle prescaler feeding an ms count).
module i2c_delay_ms #(
  parameter int CYC_W     = 16,
  parameter int MS_RELOAD = 24999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             ms_mode_i,
  input  logic [CYC_W-1:0] cyc_ld_i,
  input  logic [7:0]       ms_ld_i,
  input  logic             en_i,
  output logic             zero_o
);
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [7:0]       ms_q, ms_d;
  logic             mode_q, mode_d;

  assign zero_o = mode_q ? (ms_q == 8'd0) : (cyc_q == '0);

  always_comb begin
    cyc_d  = cyc_q;
    ms_d   = ms_q;
    mode_d = mode_q;
    if (load_i) begin
      cyc_d  = cyc_ld_i;
      ms_d   = ms_ld_i;
      mode_d = ms_mode_i;
    end else if (en_i && !zero_o) begin
      // In ms mode the cycle counter is a prescaler that rolls over once per ms.
      if (mode_q && cyc_q == '0) begin
        cyc_d = CYC_W'(MS_RELOAD);
        ms_d  = ms_q - 8'd1;
      end else begin
        cyc_d = cyc_q - CYC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q  <= '0;
      ms_q   <= '0;
      mode_q <= 1'b0;
    end else begin
      cyc_q  <= cyc_d;
      ms_q   <= ms_d;
      mode_q <= mode_d;
    end
  end
endmodule

// File: rtl/i2c_init_seq.sv
// Table-driven register-init sequencer feeding the single-byte I2C writer.
// Optional WAIT watchdog with sticky timeout output: define I2C_INIT_SEQ_TIMEOUT_EN.
module i2c_init_seq
  import i2c_pkg::*;
#(
  parameter int REGI_MSB   = 7,
  parameter int ADDR_MSB   = 7,
  parameter int MS_CYCLES  = 25000,
  parameter int GAP_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  output logic              busy,
  output logic              finished,
  output logic [ADDR_MSB:0] wr_count,
`ifdef I2C_INIT_SEQ_TIMEOUT_EN
  output logic              timeout,
`endif
  i2c_init_seq_if.master    bus
);
  localparam int CYC_MAX = (MS_CYCLES - 1 > GAP_CYCLES) ? MS_CYCLES - 1 : GAP_CYCLES;
  localparam int CYC_W   = (CYC_MAX < 2) ? 1 : $clog2(CYC_MAX + 1);

  state_t            state_q, state_d;
  logic [ADDR_MSB:0] addr_q, addr_d;
  logic [REGI_MSB:0] regi_q, regi_d;
  logic [7:0]        regv_q, regv_d;
  logic              fin_q, fin_d;
  logic [ADDR_MSB:0] wrc_q, wrc_d;
  logic [1:0]        grd_q, grd_d;
`ifdef I2C_INIT_SEQ_TIMEOUT_EN
  logic [15:0]       wd_q, wd_d;
  logic              to_q, to_d;
`endif

  logic [REGI_MSB:0] e_regi;
  logic [7:0]        e_regv;
  logic              e_esc;
  logic              cnt_ld, cnt_ms, cnt_en, cnt_zero;
  logic [CYC_W-1:0]  cnt_cyc;
  logic [7:0]        cnt_ms_ld;

  assign e_regi = bus.tbl_data[REGI_MSB+8:8];
  assign e_regv = bus.tbl_data[7:0];
  assign e_esc  = &e_regi;

  i2c_delay_ms #(
    .CYC_W    (CYC_W),
    .MS_RELOAD(MS_CYCLES - 1)
  ) u_dly (
    .clk      (clk),
    .reset    (reset),
    .load_i   (cnt_ld),
    .ms_mode_i(cnt_ms),
    .cyc_ld_i (cnt_cyc),
    .ms_ld_i  (cnt_ms_ld),
    .en_i     (cnt_en),
    .zero_o   (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    regi_d    = regi_q;
    regv_d    = regv_q;
    fin_d     = fin_q;
    wrc_d     = wrc_q;
    grd_d     = grd_q;
`ifdef I2C_INIT_SEQ_TIMEOUT_EN
    wd_d      = wd_q;
    to_d      = to_q;
`endif
    cnt_ld    = 1'b0;
    cnt_ms    = 1'b0;
    cnt_en    = 1'b0;
    cnt_cyc   = CYC_W'(GAP_CYCLES);
    cnt_ms_ld = 8'd0;
    unique case (state_q)
      IDLE: if (go) begin
        addr_d  = '0;
        wrc_d   = '0;
        fin_d   = 1'b0;
`ifdef I2C_INIT_SEQ_TIMEOUT_EN
        to_d    = 1'b0;
`endif
        state_d = FETCH;
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        if (!e_esc) begin
          regi_d  = e_regi;
          regv_d  = e_regv;
          state_d = START;
        end else if (e_regv == END_REGV) begin
          fin_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_ld    = 1'b1;
          cnt_ms    = 1'b1;
          cnt_cyc   = CYC_W'(MS_CYCLES - 1);
          cnt_ms_ld = e_regv;
          state_d   = DELAY;
        end
      end
      START: begin
        wrc_d   = wrc_q + 1'b1;
        grd_d   = 2'(GUARD_LEN - 1);
`ifdef I2C_INIT_SEQ_TIMEOUT_EN
        wd_d    = '0;
`endif
        state_d = GUARD;
      end
      // done from the previous write may still be high here; ignore it
      GUARD: begin
        if (grd_q == 2'd0) state_d = WAIT;
        else               grd_d   = grd_q - 2'd1;
      end
      WAIT: begin
        if (bus.i2c_done) begin
          cnt_ld  = 1'b1;
          state_d = GAP;
        end
`ifdef I2C_INIT_SEQ_TIMEOUT_EN
        else if (wd_q == 16'hFFFF) begin
          to_d    = 1'b1;
          cnt_ld  = 1'b1;
          state_d = GAP;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end
      GAP, DELAY: begin
        cnt_en = 1'b1;
        if (cnt_zero) state_d = ADV;
      end
      ADV: begin
        if (&addr_q) begin
          fin_d   = 1'b1;
          state_d = IDLE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      regi_q  <= '0;
      regv_q  <= '0;
      fin_q   <= 1'b0;
      wrc_q   <= '0;
      grd_q   <= '0;
`ifdef I2C_INIT_SEQ_TIMEOUT_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      regi_q  <= regi_d;
      regv_q  <= regv_d;
      fin_q   <= fin_d;
      wrc_q   <= wrc_d;
      grd_q   <= grd_d;
`ifdef I2C_INIT_SEQ_TIMEOUT_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
`endif
    end
  end

  assign bus.tbl_addr  = addr_q;
  assign bus.i2c_regi  = regi_q;
  assign bus.i2c_regv  = regv_q;
  assign bus.i2c_start = (state_q == START);
  assign busy          = (state_q != IDLE);
  assign finished      = fin_q;
  assign wr_count      = wrc_q;
`ifdef I2C_INIT_SEQ_TIMEOUT_EN
  assign timeout       = to_q;
`endif
endmodule

// File: tb/tb_i2c_init_seq.sv
// Directed bench for i2c_init_seq: sync ROM model, byte-writer done model, start monitor.
module tb_i2c_init_seq;
  localparam int REGI_MSB = 7;
  localparam int ADDR_MSB = 2;
  localparam int MS_CYC   = 10;
  localparam int GAP      = 255;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic go = 1'b0;
  logic busy, finished;
  logic [ADDR_MSB:0] wr_count;
`ifdef I2C_INIT_SEQ_TIMEOUT_EN
  logic timeout;
`endif

  i2c_init_seq_if #(.REGI_MSB(REGI_MSB), .ADDR_MSB(ADDR_MSB)) bus ();

  i2c_init_seq #(
    .REGI_MSB(REGI_MSB), .ADDR_MSB(ADDR_MSB), .MS_CYCLES(MS_CYC), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .busy(busy), .finished(finished),
    .wr_count(wr_count),
`ifdef I2C_INIT_SEQ_TIMEOUT_EN
    .timeout(timeout),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  int cyc = 0;
  logic [15:0] rom [8];
  int n_start = 0, n_done = 0, dbl = 0;
  int start_cyc [64];
  int done_cyc [64];
  logic [7:0] st_regi [64], st_regv [64];
  logic prev_start = 1'b0;
  logic wr_en = 1'b1, done_const = 1'b0;
  int wcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.tbl_data <= rom[bus.tbl_addr];

  // start monitor
  always @(negedge clk) begin
    if (bus.i2c_start) begin
      start_cyc[n_start & 63] = cyc;
      st_regi[n_start & 63]   = bus.i2c_regi;
      st_regv[n_start & 63]   = bus.i2c_regv;
      n_start = n_start + 1;
      if (prev_start) dbl = dbl + 1;
    end
    prev_start = bus.i2c_start;
  end

  // writer model: done drops on start, rises 40 clk later
  initial bus.i2c_done = 1'b0;
  always @(negedge clk) begin
    if (wr_en) begin
      if (bus.i2c_start) begin
        bus.i2c_done = 1'b0;
        wcnt = 40;
      end else if (wcnt > 0) begin
        wcnt = wcnt - 1;
        if (wcnt == 0) begin
          bus.i2c_done = 1'b1;
          done_cyc[n_done & 63] = cyc;
          n_done = n_done + 1;
        end
      end
    end else begin
      bus.i2c_done = done_const;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic go_pulse(output int g);
    tick();
    go = 1'b1;
    g = cyc;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int k = 0;
    while (n_start < n && k < budget) begin tick(); k++; end
    check(tag, 32'(n_start >= n), 32'd1);
  endtask

  task automatic wait_fin(input int budget, input string tag);
    int k = 0;
    while (!(finished && !busy) && k < budget) begin tick(); k++; end
    check(tag, 32'(finished && !busy), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},  32'(bus.tbl_addr),  32'd0);
    check({tag, "_regi"},  32'(bus.i2c_regi),  32'd0);
    check({tag, "_regv"},  32'(bus.i2c_regv),  32'd0);
    check({tag, "_start"}, 32'(bus.i2c_start), 32'd0);
    check({tag, "_busy"},  32'(busy),          32'd0);
    check({tag, "_fin"},   32'(finished),      32'd0);
    check({tag, "_wrc"},   32'(wr_count),      32'd0);
  endtask

  initial begin
    int g, b, d, s, k, tcyc;
    for (int i = 0; i < 8; i++) rom[i] = 16'h0000;
    repeat (3) tick();
    check_reset_vals("rst");
    reset = 1'b0;

    // 1: single write then end marker
    rom[0] = 16'h1280; rom[1] = 16'hFFFF;
    b = n_start;
    go_pulse(g);
    wait_starts(b + 1, 20, "t1_start_seen");
    check("t1_latency", 32'(start_cyc[b & 63] - g), 32'd3);
    check("t1_regi", 32'(st_regi[b & 63]), 32'h12);
    check("t1_regv", 32'(st_regv[b & 63]), 32'h80);
    wait_fin(1000, "t1_finished");
    check("t1_nstart", 32'(n_start - b), 32'd1);
    check("t1_wrc", 32'(wr_count), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);

    // 2: write, 2 ms delay, write; done->start = 1+256+2+1+20+1+3 = 284
    rom[0] = 16'h1101; rom[1] = 16'hFF02; rom[2] = 16'h1205; rom[3] = 16'hFFFF;
    b = n_start; d = n_done;
    go_pulse(g);
    wait_starts(b + 2, 2000, "t2_two_starts");
    k = start_cyc[(b + 1) & 63] - done_cyc[d & 63];
    check("t2_gap", 32'(k >= GAP + 20 + 7 && k <= GAP + 20 + 11), 32'd1);
    check("t2_regi2", 32'(st_regi[(b + 1) & 63]), 32'h12);
    check("t2_regv2", 32'(st_regv[(b + 1) & 63]), 32'h05);
    wait_fin(1000, "t2_finished");
    check("t2_nstart", 32'(n_start - b), 32'd2);
    check("t2_wrc", 32'(wr_count), 32'd2);

    // 3: no end marker, table wraps after 8 writes
    for (int i = 0; i < 8; i++) rom[i] = {8'h30 + 8'(i), 8'(i)};
    b = n_start;
    go_pulse(g);
    wait_fin(4000, "t3_finished");
    check("t3_nstart", 32'(n_start - b), 32'd8);
    check("t3_last_regi", 32'(st_regi[(b + 7) & 63]), 32'h37);
    check("t3_addr", 32'(bus.tbl_addr), 32'd7);
    check("t3_wrc_wrap", 32'(wr_count), 32'd0);
    repeat (400) tick();
    check("t3_no_ninth", 32'(n_start - b), 32'd8);

    // 4: reset while waiting on the 2nd write
    rom[0] = 16'h4101; rom[1] = 16'h4202; rom[2] = 16'hFFFF;
    b = n_start;
    go_pulse(g);
    wait_starts(b + 2, 1000, "t4_two_starts");
    repeat (10) tick();
    reset = 1'b1;
    #1;
    check_reset_vals("t4_rst");
    repeat (3) tick();
    reset = 1'b0;
    s = n_start;
    repeat (50) tick();
    check("t4_no_start", 32'(n_start - s), 32'd0);
    go_pulse(g);
    wait_starts(s + 1, 20, "t4_restart");
    check("t4_latency", 32'(start_cyc[s & 63] - g), 32'd3);
    check("t4_regi", 32'(st_regi[s & 63]), 32'h41);
    wait_fin(1000, "t4_finished");

    // 5: done stuck high
    wr_en = 1'b0; done_const = 1'b1;
    rom[0] = 16'h2111; rom[1] = 16'h2222; rom[2] = 16'hFFFF;
    b = n_start;
    go_pulse(g);
    wait_starts(b + 1, 20, "t5_start1");
    repeat (100) tick();
    check("t5_regi_hold", 32'(bus.i2c_regi), 32'h21);
    check("t5_regv_hold", 32'(bus.i2c_regv), 32'h11);
    wait_starts(b + 2, 1000, "t5_start2");
    k = start_cyc[(b + 1) & 63] - start_cyc[b & 63];
    check("t5_spacing", 32'(k >= GAP + 4), 32'd1);
    check("t5_regi2", 32'(st_regi[(b + 1) & 63]), 32'h22);
    wait_fin(1000, "t5_finished");
    check("t5_nstart", 32'(n_start - b), 32'd2);

`ifdef I2C_INIT_SEQ_TIMEOUT_EN
    // 6: done stuck low, watchdog advances the table
    done_const = 1'b0;
    rom[0] = 16'h5101; rom[1] = 16'h5202; rom[2] = 16'hFFFF;
    b = n_start;
    go_pulse(g);
    check("t6_to_cleared", 32'(timeout), 32'd0);
    wait_starts(b + 1, 20, "t6_start1");
    k = 0;
    while (!timeout && k < 70000) begin tick(); k++; end
    tcyc = cyc;
    check("t6_timeout", 32'(timeout), 32'd1);
    k = tcyc - start_cyc[b & 63];
    check("t6_to_delay", 32'(k >= 65536 && k <= 65542), 32'd1);
    wait_starts(b + 2, 1000, "t6_start2");
    check("t6_regi2", 32'(st_regi[(b + 1) & 63]), 32'h52);
    tick();
    reset = 1'b1;
    #1;
    check("t6_to_reset", 32'(timeout), 32'd0);
    tick();
    reset = 1'b0;
`endif

    check("single_cycle_start", 32'(dbl), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
